// File: rtl/sdp_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdp_bist_pkg
// Description : Shared types and helpers for the simple-dual-port memory BIST.
//               Holds the controller state encoding and the checkerboard
//               pattern generator used for the write/compare data.
// Revision    : 1.0 - initial release
// ============================================================================
package sdp_bist_pkg;

    localparam int c_state_w    = 3;
    localparam int c_max_dbits  = 64;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE  = 3'd0,
        ST_WR0   = 3'd1,
        ST_RD0W1 = 3'd2,
        ST_RD1   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Alternating pattern: bit i is 1 for even i, 0 for odd i, limited to
    // the lowest 'width' bits (0x55 for an 8-bit word).
    function automatic logic [c_max_dbits-1:0] gen_pattern(input int width);
        logic [c_max_dbits-1:0] p;
        p = '0;
        for (int i = 0; i < c_max_dbits; i++) begin
            if (i < width) begin
                p[i] = (i % 2 == 0);
            end
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_bist_if.sv
`default_nettype none
// ============================================================================
// Module      : sdp_bist_if
// Description : Control/status and SDP memory bus of the BIST controller.
//               master : BIST side (drives status and memory address/data)
//               slave  : host/memory side (drives start and read data)
// Ports       : start, busy, done, fail, fail_addr, fail_phase,
//               mem_we, mem_wa, mem_wd, mem_ra, mem_rd
// Revision    : 1.0 - initial release
// ============================================================================
interface sdp_bist_if #(
    parameter int WABITS = 4,
    parameter int WDBITS = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              fail;
    logic [WABITS-1:0] fail_addr;
    logic              fail_phase;
    logic              mem_we;
    logic [WABITS-1:0] mem_wa;
    logic [WDBITS-1:0] mem_wd;
    logic [WABITS-1:0] mem_ra;
    logic [WDBITS-1:0] mem_rd;

    modport master (
        input  start, mem_rd,
        output busy, done, fail, fail_addr, fail_phase,
        output mem_we, mem_wa, mem_wd, mem_ra
    );

    modport slave (
        output start, mem_rd,
        input  busy, done, fail, fail_addr, fail_phase,
        input  mem_we, mem_wa, mem_wd, mem_ra
    );
endinterface
`default_nettype wire

// File: rtl/sdp_bist_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : sdp_bist_addr_gen
// Description : Loadable up/down address counter with terminal count.
//               The counter saturates at its terminal value (all-ones when
//               counting up, zero when counting down) instead of wrapping.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_load/i_load_val - load has priority over counting
//               i_en, i_up     - count enable and direction
//               o_cnt, o_tc    - current address, terminal count reached
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_bist_addr_gen #(
    parameter int WABITS = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic [WABITS-1:0] i_load_val,
    input  wire logic              i_en,
    input  wire logic              i_up,
    output logic      [WABITS-1:0] o_cnt,
    output logic                   o_tc
);
    logic [WABITS-1:0] r_cnt;
    logic              w_tc;

    assign w_tc = i_up ? (r_cnt == {WABITS{1'b1}}) : (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && !w_tc) begin
            r_cnt <= i_up ? (r_cnt + WABITS'(1)) : (r_cnt - WABITS'(1));
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;
endmodule
`default_nettype wire

// File: rtl/sdp_bist.sv
`default_nettype none
// ============================================================================
// Module      : sdp_bist
// Description : March-style BIST for a simple-dual-port RAM with one-cycle
//               read latency: write P everywhere (WR0), read-compare P and
//               write ~P ascending (RD0W1), read-compare ~P descending (RD1).
// Ports       : clk, rst - clock, synchronous active-high reset
//               bus      - sdp_bist_if.master (start/busy/done/fail status
//                          and SDP write/read ports)
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_bist
    import sdp_bist_pkg::*;
#(
    parameter int WABITS = 4,
    parameter int WDBITS = 8,
    parameter int RABITS = WABITS,
    parameter int RDBITS = WDBITS
) (
    input  wire logic   clk,
    input  wire logic   rst,
    sdp_bist_if.master  bus
);
    localparam logic [WDBITS-1:0] c_pat = WDBITS'(gen_pattern(WDBITS));

    generate
        if ((RABITS != WABITS) || (RDBITS != WDBITS) || (WDBITS > c_max_dbits)) begin : g_param_err
            $error("sdp_bist: read/write port widths must match and WDBITS <= 64");
        end
    endgenerate

    state_t            r_state, w_state_nxt;
    logic              r_tail, w_tail_nxt;      // extra cycle closing a read phase
    logic              r_cmp_vld, r_cmp_phase;  // read issued last cycle
    logic [WABITS-1:0] r_cmp_addr;
    logic              r_fail, r_fail_phase;
    logic [WABITS-1:0] r_fail_addr;

    logic              w_start_acc, w_mismatch;
    logic              w_cnt_load, w_cnt_en, w_cnt_up, w_cnt_tc;
    logic [WABITS-1:0] w_cnt_load_val, w_cnt;
    logic              w_we;
    logic [WABITS-1:0] w_wa, w_ra;
    logic [WDBITS-1:0] w_wd;

    sdp_bist_addr_gen #(.WABITS(WABITS)) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_cnt_en),
        .i_up       (w_cnt_up),
        .o_cnt      (w_cnt),
        .o_tc       (w_cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tail_nxt     = r_tail;
        w_start_acc    = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_en       = 1'b0;
        w_cnt_up       = 1'b1;
        w_we           = 1'b0;
        w_wa           = '0;
        w_wd           = '0;
        w_ra           = '0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_load = 1'b1;
                w_tail_nxt = 1'b0;
                if (bus.start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = ST_WR0;
                end
            end
            ST_WR0: begin
                w_we     = 1'b1;
                w_wa     = w_cnt;
                w_wd     = c_pat;
                // No read is needed here; ~addr keeps the read port off the write address.
                w_ra     = ~w_cnt;
                w_cnt_en = 1'b1;
                if (w_cnt_tc) begin
                    w_cnt_load  = 1'b1;
                    w_state_nxt = ST_RD0W1;
                end
            end
            ST_RD0W1: begin
                // Write-back of ~P trails the read of the same address by one cycle.
                w_we = r_cmp_vld;
                if (r_cmp_vld) begin
                    w_wa = r_cmp_addr;
                    w_wd = ~c_pat;
                end
                if (r_tail) begin
                    w_tail_nxt     = 1'b0;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = '1;
                    w_state_nxt    = ST_RD1;
                end else begin
                    w_ra     = w_cnt;
                    w_cnt_en = 1'b1;
                    if (w_cnt_tc) begin
                        w_tail_nxt = 1'b1;
                    end
                end
            end
            ST_RD1: begin
                w_cnt_up = 1'b0;
                if (r_tail) begin
                    w_tail_nxt  = 1'b0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_ra     = w_cnt;
                    w_cnt_en = 1'b1;
                    if (w_cnt_tc) begin
                        w_tail_nxt = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read data returns one cycle after the address, so remember what was read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_vld   <= 1'b0;
            r_cmp_phase <= 1'b0;
            r_cmp_addr  <= '0;
        end else begin
            r_cmp_vld   <= ((r_state == ST_RD0W1) || (r_state == ST_RD1)) && !r_tail;
            r_cmp_phase <= (r_state == ST_RD1);
            r_cmp_addr  <= w_cnt;
        end
    end

    assign w_mismatch = r_cmp_vld && (bus.mem_rd != (r_cmp_phase ? ~c_pat : c_pat));

    // Only the first mismatch of a run is recorded.
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_fail       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_phase <= 1'b0;
        end else if (w_mismatch && !r_fail) begin
            r_fail       <= 1'b1;
            r_fail_addr  <= r_cmp_addr;
            r_fail_phase <= r_cmp_phase;
        end
    end

    assign bus.busy       = (r_state == ST_WR0) || (r_state == ST_RD0W1) || (r_state == ST_RD1);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.fail       = r_fail;
    assign bus.fail_addr  = r_fail_addr;
    assign bus.fail_phase = r_fail_phase;
    assign bus.mem_we     = w_we;
    assign bus.mem_wa     = w_wa;
    assign bus.mem_wd     = w_wd;
    assign bus.mem_ra     = w_ra;
endmodule
`default_nettype wire

// File: tb/tb_sdp_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdp_bist
// Description : Self-checking bench for sdp_bist (WABITS=4, WDBITS=8) with a
//               behavioural SDP memory that can hold one stuck-at-0 bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdp_bist;
    localparam int c_wa    = 4;
    localparam int c_wd    = 8;
    localparam int c_depth = 16;

    typedef struct {
        bit fault_en;
        int faddr;
        int fbit;
        bit exp_fail;
        int exp_faddr;
        bit exp_phase;
    } vec_t;

    typedef struct {
        logic [c_wa-1:0] addr;
        logic [c_wd-1:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    bit   f_en = 1'b0;
    int   f_addr = 0;
    int   f_bit = 0;
    logic [c_wd-1:0] mem [c_depth];
    wr_t  exp_q[$];
    vec_t vecs[4];

    sdp_bist_if #(.WABITS(c_wa), .WDBITS(c_wd)) bus ();

    sdp_bist #(.WABITS(c_wa), .WDBITS(c_wd)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [c_wd-1:0] apply_fault(input logic [c_wa-1:0] a, input logic [c_wd-1:0] d);
        logic [c_wd-1:0] r;
        r = d;
        if (f_en && (int'(a) == f_addr)) r[f_bit] = 1'b0;
        return r;
    endfunction

    // Behavioural SDP RAM: registered read, one-cycle latency.
    always @(posedge clk) begin
        bus.mem_rd <= mem[bus.mem_ra];
        if (bus.mem_we) mem[bus.mem_wa] <= apply_fault(bus.mem_wa, bus.mem_wd);
    end

    // Write scoreboard and port-collision check, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.mem_we) begin
            check("we_wa_ne_ra", 32'(bus.mem_wa == bus.mem_ra), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.mem_wa), 32'(e.addr));
                check("wr_data", 32'(bus.mem_wd), 32'(e.data));
            end
        end
    end

    task automatic push_expected();
        wr_t e;
        for (int i = 0; i < c_depth; i++) begin
            e.addr = c_wa'(i); e.data = 8'h55; exp_q.push_back(e);
        end
        for (int i = 0; i < c_depth; i++) begin
            e.addr = c_wa'(i); e.data = 8'hAA; exp_q.push_back(e);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit hold_start);
        int n;
        int d0;
        bit seen;
        f_en = v.fault_en; f_addr = v.faddr; f_bit = v.fbit;
        push_expected();
        d0 = done_cnt;
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("fail_cleared", 32'(bus.fail), 32'd0);
        n = 0; seen = 1'b0;
        while (n < 200 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        check("done_latency", 32'(n), 32'(3 * c_depth + 2));
        check("busy_in_done", 32'(bus.busy), 32'd0);
        check("fail", 32'(bus.fail), 32'(v.exp_fail));
        if (v.exp_fail) begin
            check("fail_addr", 32'(bus.fail_addr), 32'(v.exp_faddr));
            check("fail_phase", 32'(bus.fail_phase), 32'(v.exp_phase));
        end
        @(posedge clk); #1;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("done_count", 32'(done_cnt - d0), 32'd1);
        check("writes_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int  n;
        int  d0;
        bit  found;
        vec_t v;

        for (int i = 0; i < c_depth; i++) mem[i] = '0;
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_fail", 32'(bus.fail), 32'd0);
        check("rst_fail_addr", 32'(bus.fail_addr), 32'd0);
        check("rst_fail_phase", 32'(bus.fail_phase), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_wa", 32'(bus.mem_wa), 32'd0);
        check("rst_mem_wd", 32'(bus.mem_wd), 32'd0);
        check("rst_mem_ra", 32'(bus.mem_ra), 32'd0);
        @(negedge clk); rst = 1'b0;

        //            fault  addr bit  fail faddr phase
        vecs[0] = '{1'b0,  0,   0,  1'b0, 0,    1'b0};
        vecs[1] = '{1'b1,  5,   0,  1'b1, 5,    1'b0};
        vecs[2] = '{1'b1,  9,   7,  1'b1, 9,    1'b1};
        vecs[3] = '{1'b0,  0,   0,  1'b0, 0,    1'b0};
        for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b0);

        // Reset in RD0W1 while reading address 7.
        v = vecs[0];
        f_en = 1'b0;
        push_expected();
        d0 = done_cnt;
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        found = 1'b0; n = 0;
        while (n < 100 && !found) begin
            if (bus.mem_we && bus.mem_ra == 4'd7 && bus.mem_wa == 4'd6) found = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        check("rst_point_found", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_mem_we", 32'(bus.mem_we), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        exp_q.delete();
        repeat (60) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_vec(v, 1'b0);

        // Reset and start together: reset wins.
        @(negedge clk); rst = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        check("rst_start_busy", 32'(bus.busy), 32'd0);
        @(negedge clk); rst = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        check("rst_start_idle", 32'(bus.busy), 32'd0);

        // start held high for the whole run: still exactly one done.
        run_vec(vecs[0], 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("held_start_idle", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
